operand_loader: RTL and testbench

//  Upstream operand-entry stage for the 8-bit two's-complement add/sub datapath.

---
 rtl/operand_loader_if.sv | 18 +
 rtl/operand_loader.sv | 145 ++++++++++++++
 tb/tb_operand_loader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_if.sv
// Operand handshake bundle between the operand loader and the adder stage.
//   valid : operands presented, held until accepted
//   ready : adder stage accepts operands
//   a, b  : operands A and B (WIDTH bits)
//   sub   : operation select, 1 = A-B
// master: loader side (drives valid/a/b/sub). slave: adder side (drives ready).
interface operand_loader_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;

  modport master (output valid, output a, output b, output sub, input ready);
  modport slave  (input valid, input a, input b, input sub, output ready);
endinterface

// File: rtl/operand_loader.sv
// operand_loader: operand-entry stage for the 8-bit add/sub datapath.
// Debounces a raw active-low push-key and steps LOAD_A -> LOAD_B -> ISSUE,
// capturing DATA as A, then DATA/SUB as B/sub, then offering {A,B,sub}
// downstream over a valid/ready handshake.
// Ports:
//   CLK   : clock, all state on rising edge
//   RST   : asynchronous reset, active-high
//   KEY_N : raw push-key, active-low, asynchronous, bouncy
//   DATA  : switch word, sampled on an accepted press
//   SUB   : subtract select, sampled together with B
//   out   : operand handshake (master modport of operand_loader_if)
//   state : 00 LOAD_A, 01 LOAD_B, 10 ISSUE (status display)
// Build option: define LOADER_TIMEOUT_EN to abort LOAD_B back to LOAD_A after
// TIMEOUT_CYCLES press-free cycles; without it LOAD_B waits indefinitely.
module operand_loader #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                KEY_N,
  input  logic [WIDTH-1:0]    DATA,
  input  logic                SUB,
  operand_loader_if.master    out,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_ISSUE  = 2'b10
  } state_t;

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  state_t         state_q, state_d;
  logic           sync1, key_s, level;
  logic [CW-1:0]  db_cnt;
  logic           mismatch, settle, press;
  logic           capture_a, capture_b, valid_d, timeout;

  // Key synchronizer and debouncer
  assign mismatch = (key_s != level);
  assign settle   = mismatch && (db_cnt == CW'(DEBOUNCE_CYCLES - 1));
  // Press fires in the cycle the debounced level is about to fall, so the
  // FSM captures on the same edge the level changes.
  assign press    = settle && !key_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= 1'b1;
      key_s  <= 1'b1;
      level  <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= KEY_N;
      key_s <= sync1;
      if (!mismatch) begin
        db_cnt <= '0;
      end else if (settle) begin
        level  <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  assign timeout = (state_q == S_LOAD_B) && !press &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idle_cnt <= '0;
    end else if ((state_q != S_LOAD_B) || press || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_LOAD_A;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    capture_a = 1'b0;
    capture_b = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        if (press) begin
          capture_a = 1'b1;
          state_d   = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (press) begin
          capture_b = 1'b1;
          state_d   = S_ISSUE;
        end else if (timeout) begin
          state_d = S_LOAD_A;
        end
      end
      S_ISSUE: begin
        if (out.valid && out.ready) state_d = S_LOAD_A;
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  // Outputs: valid is registered from the next state so it rises on ISSUE entry
  always_comb begin
    valid_d = (state_d == S_ISSUE);
    state   = state_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out.valid <= 1'b0;
      out.a     <= '0;
      out.b     <= '0;
      out.sub   <= 1'b0;
    end else begin
      out.valid <= valid_d;
      if (capture_a) out.a <= DATA;
      if (capture_b) begin
        out.b   <= DATA;
        out.sub <= SUB;
      end
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned T = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         KEY_N;
  logic         SUB;
  logic [W-1:0] DATA;
  logic [1:0]   state;

  operand_loader_if #(.WIDTH(W)) bus ();

  operand_loader #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .KEY_N(KEY_N),
    .DATA(DATA),
    .SUB(SUB),
    .out(bus.master),
    .state(state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [2*W:0] sb[$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    repeat (8) step();
  endtask

  // Drive a clean press; capture lands on the 6th edge. Key is released on return.
  task automatic press_key(input logic [W-1:0] d, input logic s, input logic [1:0] exp_state);
    DATA  = d;
    SUB   = s;
    KEY_N = 1'b0;
    repeat (D + 2) step();
    checks++;
    if (state !== exp_state) begin
      errors++;
      $display("FAIL press_state: got %b expected %b", state, exp_state);
    end
    KEY_N = 1'b1;
  endtask

  // Serve the ISSUE phase: ready held low for 'hold' valid cycles, then high.
  task automatic run_issue(input int hold, input bit poke);
    int vcount;
    bit done;
    logic [W-1:0] a_before;
    vcount = 0;
    done   = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.valid === 1'b1) begin
        vcount++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: got valid with a=%h b=%h, expected no transaction", bus.a, bus.b);
          done = 1'b1;
        end else begin
          if ({bus.a, bus.b, bus.sub} !== sb[0]) begin
            errors++;
            $display("FAIL issue_operands: got %h expected %h", {bus.a, bus.b, bus.sub}, sb[0]);
          end
          if (poke) begin
            if (vcount == 1) KEY_N = 1'b0;
            if (vcount == 8) KEY_N = 1'b1;
          end
          bus.ready = (vcount > hold);
          if (bus.ready) begin
            void'(sb.pop_front());
            done = 1'b1;
          end
        end
      end
      step();
    end
    bus.ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout: got no handshake, expected one within 100 cycles");
    end
    checks++;
    if (vcount != hold + 1) begin
      errors++;
      $display("FAIL issue_valid_cycles: got %0d expected %0d", vcount, hold + 1);
    end
    checks++;
    if (bus.valid !== 1'b0 || state !== 2'b00) begin
      errors++;
      $display("FAIL issue_exit: got valid=%b state=%b expected valid=0 state=00", bus.valid, state);
    end
    if (poke) begin
      a_before = bus.a;
      settle();
      settle();
      checks++;
      if (state !== 2'b00 || bus.a !== a_before) begin
        errors++;
        $display("FAIL issue_press_ignored: got state=%b a=%h expected state=00 a=%h", state, bus.a, a_before);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; KEY_N = 1'b1; DATA = '0; SUB = 1'b0; bus.ready = 1'b0;
    step(); step();
    checks++;
    if (state !== 2'b00 || bus.valid !== 1'b0 || bus.a !== 8'h00 || bus.b !== 8'h00 || bus.sub !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got state=%b v=%b a=%h b=%h s=%b expected 00 0 00 00 0",
               state, bus.valid, bus.a, bus.b, bus.sub);
    end
    RST = 1'b0;
    step();
    press_key(8'h3C, 1'b0, 2'b01);
    checks++;
    if (bus.a !== 8'h3C) begin
      errors++;
      $display("FAIL reset_preload_a: got %h expected 3c", bus.a);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (state !== 2'b00 || bus.a !== 8'h00 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_load_b: got state=%b a=%h v=%b expected 00 00 0", state, bus.a, bus.valid);
    end
    RST = 1'b0;
    step();
    settle();
    // Reset with a pending valid in ISSUE
    press_key(8'h11, 1'b0, 2'b01);
    settle();
    press_key(8'h22, 1'b1, 2'b10);
    checks++;
    if (bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_issue_valid: got %b expected 1", bus.valid);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (state !== 2'b00 || bus.valid !== 1'b0 || bus.b !== 8'h00 || bus.sub !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_issue: got state=%b v=%b b=%h s=%b expected 00 0 00 0", state, bus.valid, bus.b, bus.sub);
    end
    RST = 1'b0;
    step();
    settle();
  endtask

  task automatic test_basic_add();
    bus.ready = 1'b1;
    press_key(8'h25, 1'b0, 2'b01);
    settle();
    press_key(8'h1A, 1'b0, 2'b10);
    sb.push_back({8'h25, 8'h1A, 1'b0});
    run_issue(0, 1'b0);
    settle();
  endtask

  task automatic test_backpressure_sub();
    press_key(8'h80, 1'b0, 2'b01);
    settle();
    press_key(8'h01, 1'b1, 2'b10);
    sb.push_back({8'h80, 8'h01, 1'b1});
    run_issue(10, 1'b1);
  endtask

  task automatic test_bounce();
    bit bad;
    int n;
    bad  = 1'b0;
    DATA = 8'h55;
    SUB  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      KEY_N = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      if (state !== 2'b00 || bus.a !== 8'h80) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bounce_no_press: got state=%b a=%h expected state=00 a=80", state, bus.a);
    end
    KEY_N = 1'b0;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      step();
      if (state === 2'b01) n = k;
    end
    checks++;
    if (n != D + 2) begin
      errors++;
      $display("FAIL bounce_latency: got %0d edges expected %0d", n, D + 2);
    end
    checks++;
    if (bus.a !== 8'h55) begin
      errors++;
      $display("FAIL bounce_capture: got %h expected 55", bus.a);
    end
    KEY_N = 1'b1;
    settle();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL bounce_single_advance: got %b expected 01", state);
    end
    press_key(8'h11, 1'b0, 2'b10);
    sb.push_back({8'h55, 8'h11, 1'b0});
    run_issue(0, 1'b0);
    settle();
  endtask

  task automatic test_latency();
    DATA  = 8'hA5;
    SUB   = 1'b0;
    KEY_N = 1'b0;
    for (int k = 1; k <= D + 2; k++) begin
      step();
      checks++;
      if (k < D + 2) begin
        if (state !== 2'b00) begin
          errors++;
          $display("FAIL latency_early_edge%0d: got %b expected 00", k, state);
        end
      end else if (state !== 2'b01 || bus.a !== 8'hA5) begin
        errors++;
        $display("FAIL latency_capture: got state=%b a=%h expected 01 a5", state, bus.a);
      end
    end
    DATA = 8'h5A;
    repeat (3) step();
    checks++;
    if (bus.a !== 8'hA5) begin
      errors++;
      $display("FAIL latency_hold_a: got %h expected a5", bus.a);
    end
    KEY_N = 1'b1;
    settle();
    press_key(8'hC3, 1'b1, 2'b10);
    sb.push_back({8'hA5, 8'hC3, 1'b1});
    run_issue(2, 1'b0);
    settle();
  endtask

  task automatic test_timeout();
    press_key(8'h7F, 1'b0, 2'b01);
`ifdef LOADER_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int k = 1; k <= 60 && n == 0; k++) begin
        step();
        if (state === 2'b00) n = k;
      end
      checks++;
      if (n != T) begin
        errors++;
        $display("FAIL timeout_cycles: got %0d expected %0d", n, T);
      end
      checks++;
      if (bus.a !== 8'h7F) begin
        errors++;
        $display("FAIL timeout_keep_a: got %h expected 7f", bus.a);
      end
      press_key(8'h01, 1'b0, 2'b01);
      settle();
      press_key(8'h02, 1'b1, 2'b10);
      sb.push_back({8'h01, 8'h02, 1'b1});
    end
`else
    repeat (100) step();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL no_timeout_wait: got %b expected 01", state);
    end
    press_key(8'h02, 1'b1, 2'b10);
    sb.push_back({8'h7F, 8'h02, 1'b1});
`endif
    run_issue(0, 1'b0);
    settle();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_backpressure_sub();
    test_bounce();
    test_latency();
    test_timeout();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
